// File: rtl/nand_pkg.sv
// Shared encodings for the NAND operation sequencer: op codes, command bytes,
// beat modes, FSM states and wait-phase limits.
package nand_pkg;

    localparam logic [1:0] OP_RESET   = 2'd0;
    localparam logic [1:0] OP_READ    = 2'd1;
    localparam logic [1:0] OP_PROGRAM = 2'd2;
    localparam logic [1:0] OP_ERASE   = 2'd3;

    localparam logic [7:0] CMD_RESET  = 8'hFF;
    localparam logic [7:0] CMD_READ1  = 8'h00;
    localparam logic [7:0] CMD_READ2  = 8'h30;
    localparam logic [7:0] CMD_PROG1  = 8'h80;
    localparam logic [7:0] CMD_PROG2  = 8'h10;
    localparam logic [7:0] CMD_ERASE1 = 8'h60;
    localparam logic [7:0] CMD_ERASE2 = 8'hD0;

    localparam logic [1:0] MODE_CMD  = 2'd0;
    localparam logic [1:0] MODE_ADDR = 2'd1;
    localparam logic [1:0] MODE_DATA = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD1,
        ST_ADDR,
        ST_DATA,
        ST_CMD2,
        ST_WAIT_LO,
        ST_WAIT_HI,
        ST_FIN
    } state_e;

    localparam logic [23:0] WAIT_LO_LIMIT   = 24'd64;
    localparam logic [23:0] WAIT_HI_TIMEOUT = 24'hFFFFFF;

    function automatic logic [7:0] cmd1_byte(input logic [1:0] op);
        case (op)
            OP_RESET:   return CMD_RESET;
            OP_READ:    return CMD_READ1;
            OP_PROGRAM: return CMD_PROG1;
            default:    return CMD_ERASE1;
        endcase
    endfunction

    function automatic logic [7:0] cmd2_byte(input logic [1:0] op);
        case (op)
            OP_READ:    return CMD_READ2;
            OP_PROGRAM: return CMD_PROG2;
            default:    return CMD_ERASE2;
        endcase
    endfunction

endpackage

// File: rtl/rb_sync.sv
// Two-flop synchroniser for the target's asynchronous ready/busy line.
// Resets to "ready" so a freshly reset sequencer never sees a phantom busy.
module rb_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic rb_i,
    output logic rb_sync_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= rb_i;
            sync_q <= meta_q;
        end
    end

    assign rb_sync_o = sync_q;

endmodule

// File: rtl/nand_op_seq.sv
// NAND operation sequencer: turns one host request into command/address/data
// beats for the cycle driver, then waits out the target's busy phase.
module nand_op_seq
    import nand_pkg::*;
#(
    parameter logic [23:0] HI_TIMEOUT = WAIT_HI_TIMEOUT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [1:0]  req_op_i,
    input  logic [15:0] req_col_i,
    input  logic [23:0] req_row_i,
    input  logic [12:0] req_len_i,
    input  logic [7:0]  wdata_i,
    input  logic        wdata_valid_i,
    output logic        wdata_ready_o,
    output logic [1:0]  mode_o,
    output logic [7:0]  ioh_o,
    output logic        cyc_valid_o,
    input  logic        cyc_ready_i,
    input  logic        rb_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    state_e      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [15:0] col_q, col_d;
    logic [23:0] row_q, row_d;
    logic [12:0] len_q, len_d;
    logic [2:0]  addr_idx_q, addr_idx_d;
    logic [12:0] data_cnt_q, data_cnt_d;
    logic [23:0] wait_cnt_q, wait_cnt_d;
    logic        err_q, err_d;
    logic        rb_s;
    logic [7:0]  addr_byte;

    rb_sync u_rb_sync (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .rb_i      (rb_i),
        .rb_sync_o (rb_s)
    );

    // Address index 0..1 selects column bytes, 2..4 row bytes; erase starts at 2.
    always_comb begin
        case (addr_idx_q)
            3'd0:    addr_byte = col_q[7:0];
            3'd1:    addr_byte = col_q[15:8];
            3'd2:    addr_byte = row_q[7:0];
            3'd3:    addr_byte = row_q[15:8];
            default: addr_byte = row_q[23:16];
        endcase
    end

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        col_d         = col_q;
        row_d         = row_q;
        len_d         = len_q;
        addr_idx_d    = addr_idx_q;
        data_cnt_d    = data_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        err_d         = err_q;
        req_ready_o   = 1'b0;
        cyc_valid_o   = 1'b0;
        wdata_ready_o = 1'b0;
        mode_o        = MODE_CMD;
        ioh_o         = 8'h00;
        done_o        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    op_d       = req_op_i;
                    col_d      = req_col_i;
                    row_d      = req_row_i;
                    len_d      = (req_len_i == 13'd0) ? 13'd1 : req_len_i;
                    addr_idx_d = (req_op_i == OP_ERASE) ? 3'd2 : 3'd0;
                    data_cnt_d = 13'd0;
                    wait_cnt_d = 24'd0;
                    err_d      = 1'b0;
                    state_d    = ST_CMD1;
                end
            end
            ST_CMD1: begin
                cyc_valid_o = 1'b1;
                ioh_o       = cmd1_byte(op_q);
                if (cyc_ready_i) begin
                    state_d = (op_q == OP_RESET) ? ST_WAIT_LO : ST_ADDR;
                end
            end
            ST_ADDR: begin
                cyc_valid_o = 1'b1;
                mode_o      = MODE_ADDR;
                ioh_o       = addr_byte;
                if (cyc_ready_i) begin
                    if (addr_idx_q == 3'd4) begin
                        state_d = (op_q == OP_PROGRAM) ? ST_DATA : ST_CMD2;
                    end else begin
                        addr_idx_d = addr_idx_q + 3'd1;
                    end
                end
            end
            // Data beats are a straight pass-through of the host write stream.
            ST_DATA: begin
                mode_o        = MODE_DATA;
                ioh_o         = wdata_i;
                cyc_valid_o   = wdata_valid_i;
                wdata_ready_o = cyc_ready_i;
                if (wdata_valid_i && cyc_ready_i) begin
                    data_cnt_d = data_cnt_q + 13'd1;
                    if (data_cnt_q + 13'd1 == len_q) begin
                        state_d = ST_CMD2;
                    end
                end
            end
            ST_CMD2: begin
                cyc_valid_o = 1'b1;
                ioh_o       = cmd2_byte(op_q);
                if (cyc_ready_i) begin
                    state_d    = ST_WAIT_LO;
                    wait_cnt_d = 24'd0;
                end
            end
            // A target that never drops RB is assumed to have already finished.
            ST_WAIT_LO: begin
                if (!rb_s || (wait_cnt_q == WAIT_LO_LIMIT - 24'd1)) begin
                    state_d    = ST_WAIT_HI;
                    wait_cnt_d = 24'd0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 24'd1;
                end
            end
            ST_WAIT_HI: begin
                if (rb_s) begin
                    state_d = ST_FIN;
                end else if (wait_cnt_q == HI_TIMEOUT - 24'd1) begin
                    err_d   = 1'b1;
                    state_d = ST_FIN;
                end else begin
                    wait_cnt_d = wait_cnt_q + 24'd1;
                end
            end
            ST_FIN: begin
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_RESET;
            col_q      <= 16'd0;
            row_q      <= 24'd0;
            len_q      <= 13'd0;
            addr_idx_q <= 3'd0;
            data_cnt_q <= 13'd0;
            wait_cnt_q <= 24'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            col_q      <= col_d;
            row_q      <= row_d;
            len_q      <= len_d;
            addr_idx_q <= addr_idx_d;
            data_cnt_q <= data_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

    assign busy_o = (state_q != ST_IDLE);
    assign err_o  = err_q;

endmodule
